vec_acc_driver: RTL and testbench

VEC_ACC_DRIVER -- requirements
Module: vec_acc_driver

---
 rtl/vec_acc_driver.sv | 168 ++++++++++++++++
 tb/tb_vec_acc_driver.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_acc_driver.sv
// Sequencer that loads complex double vectors, drives a vector multiply-accumulate unit and streams its results.
// Optional watchdog on WAIT_DONE is enabled with macro VEC_ACC_DRIVER_TIMEOUT_EN.
module vec_acc_driver #(
   parameter int mat_add_gen = 2,
   parameter int rows        = 4,
   parameter int timeout     = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      go,
   input  logic [63:0]               in_real,
   input  logic [63:0]               in_imag,
   input  logic                      in_stb,
   output logic                      in_ack,
   output logic [64*mat_add_gen-1:0] a_real,
   output logic [64*mat_add_gen-1:0] a_imag,
   output logic [64*mat_add_gen-1:0] b_real,
   output logic [64*mat_add_gen-1:0] b_imag,
   output logic                      valid,
   output logic                      start,
   output logic                      out_read_ack,
   input  logic [63:0]               z_real,
   input  logic [63:0]               z_imag,
   input  logic                      done,
   output logic [63:0]               res_real,
   output logic [63:0]               res_imag,
   output logic                      res_stb,
   input  logic                      res_ack,
   output logic                      busy,
   output logic                      err
);

   localparam int KW = (mat_add_gen > 1) ? $clog2(mat_add_gen) : 1;
   localparam logic [KW-1:0] K_LAST   = KW'(mat_add_gen - 1);
   localparam logic [15:0]   ROW_LAST = 16'(rows - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD_X, LOAD_ROW, ISSUE, WAIT_DONE, RELEASE, WAIT_CLR, EMIT
   } state_t;

   state_t state, state_nxt;
   logic [KW-1:0] k;
   logic [15:0]   row_cnt;
   logic          take;
   logic          timeout_hit;
   logic          abort_ack;

   assign take = in_ack && in_stb;

`ifdef VEC_ACC_DRIVER_TIMEOUT_EN
   logic [31:0] wait_cnt;

   // Counts cycles spent in WAIT_DONE; a late done still wins over the watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state == WAIT_DONE) begin
         wait_cnt <= wait_cnt + 32'd1;
      end else begin
         wait_cnt <= '0;
      end
   end

   assign timeout_hit = (state == WAIT_DONE) && !done && (wait_cnt == 32'(timeout - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err       <= 1'b0;
         abort_ack <= 1'b0;
      end else begin
         abort_ack <= timeout_hit;
         if (timeout_hit) begin
            err <= 1'b1;
         end else if ((state == IDLE) && go) begin
            err <= 1'b0;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign abort_ack   = 1'b0;
   assign err         = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (go) state_nxt = LOAD_X;
         LOAD_X:    if (take && (k == K_LAST)) state_nxt = LOAD_ROW;
         LOAD_ROW:  if (take && (k == K_LAST)) state_nxt = ISSUE;
         ISSUE:     state_nxt = WAIT_DONE;
         WAIT_DONE: begin
            if (done) begin
               state_nxt = RELEASE;
            end else if (timeout_hit) begin
               state_nxt = IDLE;
            end
         end
         RELEASE:   state_nxt = WAIT_CLR;
         // done lingers after out_read_ack; the old result must not be re-taken.
         WAIT_CLR:  if (!done) state_nxt = EMIT;
         EMIT: begin
            if (res_ack) begin
               state_nxt = (row_cnt == ROW_LAST) ? IDLE : LOAD_ROW;
            end
         end
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ack       = (state == LOAD_X) || (state == LOAD_ROW);
      valid        = (state == ISSUE) || (state == WAIT_DONE);
      start        = (state == ISSUE) || (state == WAIT_DONE);
      out_read_ack = (state == RELEASE) || abort_ack;
      res_stb      = (state == EMIT);
      busy         = (state != IDLE);
   end

   // Operand slots are only written while loading, so they stay stable through the handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k        <= '0;
         row_cnt  <= '0;
         a_real   <= '0;
         a_imag   <= '0;
         b_real   <= '0;
         b_imag   <= '0;
         res_real <= '0;
         res_imag <= '0;
      end else begin
         if ((state == IDLE) && go) begin
            row_cnt <= '0;
            k       <= '0;
         end
         if (take) begin
            k <= (k == K_LAST) ? '0 : k + 1'b1;
            for (int i = 0; i < mat_add_gen; i++) begin
               if (k == KW'(i)) begin
                  if (state == LOAD_X) begin
                     b_real[i*64 +: 64] <= in_real;
                     b_imag[i*64 +: 64] <= in_imag;
                  end else begin
                     a_real[i*64 +: 64] <= in_real;
                     a_imag[i*64 +: 64] <= in_imag;
                  end
               end
            end
         end
         if ((state == WAIT_DONE) && done) begin
            res_real <= z_real;
            res_imag <= z_imag;
         end
         if ((state == EMIT) && res_ack && (row_cnt != ROW_LAST)) begin
            row_cnt <= row_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_vec_acc_driver.sv
// Directed bench for vec_acc_driver: a rows=1 and a rows=2 instance, each with a clocked multiply-accumulate responder.
// Build with VEC_ACC_DRIVER_TIMEOUT_EN defined to exercise the watchdog abort.
module tb_vec_acc_driver;

   localparam int N = 2;
   localparam int W = 64 * N;

   localparam logic [63:0] ZERO  = 64'h0000000000000000;
   localparam logic [63:0] ONE   = 64'h3FF0000000000000;
   localparam logic [63:0] TWO   = 64'h4000000000000000;
   localparam logic [63:0] THREE = 64'h4008000000000000;
   localparam logic [63:0] HALF  = 64'h3FE0000000000000;
   localparam logic [63:0] MONE  = 64'hBFF0000000000000;
   localparam logic [63:0] MTWO  = 64'hC000000000000000;
   localparam logic [W-1:0] X_BR = {ZERO, ONE};
   localparam logic [W-1:0] X_BI = {ONE, ZERO};

   typedef struct {
      string       name;
      logic [63:0] ar0, ai0, ar1, ai1;
      logic [63:0] er, ei;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        go[2], in_stb[2], res_ack[2], done[2];
   logic [63:0] in_real[2], in_imag[2], z_real[2], z_imag[2];
   logic        in_ack[2], valid[2], start[2], out_read_ack[2], res_stb[2], busy[2], err[2];
   logic [W-1:0] a_real[2], a_imag[2], b_real[2], b_imag[2];
   logic [63:0] res_real[2], res_imag[2];

   int resp_lat[2];
   bit resp_never[2];
   int rs[2], rcnt[2];
   int acc_cnt[2]  = '{0, 0};
   int emit_cyc[2] = '{0, 0};
   int load_cnt[2] = '{0, 0};

   int checks = 0;
   int passes = 0;

   vec_acc_driver #(.mat_add_gen(N), .rows(1), .timeout(16)) u_dut1 (
      .clk(clk), .rst(rst), .go(go[0]), .in_real(in_real[0]), .in_imag(in_imag[0]),
      .in_stb(in_stb[0]), .in_ack(in_ack[0]), .a_real(a_real[0]), .a_imag(a_imag[0]),
      .b_real(b_real[0]), .b_imag(b_imag[0]), .valid(valid[0]), .start(start[0]),
      .out_read_ack(out_read_ack[0]), .z_real(z_real[0]), .z_imag(z_imag[0]), .done(done[0]),
      .res_real(res_real[0]), .res_imag(res_imag[0]), .res_stb(res_stb[0]), .res_ack(res_ack[0]),
      .busy(busy[0]), .err(err[0])
   );

   vec_acc_driver #(.mat_add_gen(N), .rows(2), .timeout(16)) u_dut2 (
      .clk(clk), .rst(rst), .go(go[1]), .in_real(in_real[1]), .in_imag(in_imag[1]),
      .in_stb(in_stb[1]), .in_ack(in_ack[1]), .a_real(a_real[1]), .a_imag(a_imag[1]),
      .b_real(b_real[1]), .b_imag(b_imag[1]), .valid(valid[1]), .start(start[1]),
      .out_read_ack(out_read_ack[1]), .z_real(z_real[1]), .z_imag(z_imag[1]), .done(done[1]),
      .res_real(res_real[1]), .res_imag(res_imag[1]), .res_stb(res_stb[1]), .res_ack(res_ack[1]),
      .busy(busy[1]), .err(err[1])
   );

   // Complex dot product sum(a_i * b_i) of the packed operands.
   function automatic logic [127:0] mac(input logic [W-1:0] ar, ai, br, bi);
      real sr, si, xr, xi, yr, yi;
      sr = 0.0;
      si = 0.0;
      for (int i = 0; i < N; i++) begin
         xr = $bitstoreal(ar[64*i +: 64]);
         xi = $bitstoreal(ai[64*i +: 64]);
         yr = $bitstoreal(br[64*i +: 64]);
         yi = $bitstoreal(bi[64*i +: 64]);
         sr = sr + (xr * yr - xi * yi);
         si = si + (xr * yi + xi * yr);
      end
      return {$realtobits(sr), $realtobits(si)};
   endfunction

   // Responder: done after resp_lat cycles, held three cycles past out_read_ack.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            done[d]   <= 1'b0;
            z_real[d] <= '0;
            z_imag[d] <= '0;
            rs[d]     <= 0;
            rcnt[d]   <= 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            case (rs[d])
               0: if (valid[d] && start[d] && !resp_never[d]) begin
                     rs[d]   <= 1;
                     rcnt[d] <= 0;
                  end
               1: if (rcnt[d] >= resp_lat[d] - 1) begin
                     done[d] <= 1'b1;
                     {z_real[d], z_imag[d]} <= mac(a_real[d], a_imag[d], b_real[d], b_imag[d]);
                     rs[d]   <= 2;
                  end else begin
                     rcnt[d] <= rcnt[d] + 1;
                  end
               2: if (out_read_ack[d]) begin
                     rs[d]   <= 3;
                     rcnt[d] <= 0;
                  end
               default: if (rcnt[d] == 2) begin
                     done[d] <= 1'b0;
                     rs[d]   <= 0;
                  end else begin
                     rcnt[d] <= rcnt[d] + 1;
                  end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            if (res_stb[d] && res_ack[d]) acc_cnt[d] <= acc_cnt[d] + 1;
            if (res_stb[d]) emit_cyc[d] <= emit_cyc[d] + 1;
            if (in_stb[d] && in_ack[d]) load_cnt[d] <= load_cnt[d] + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         passes++;
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_go(input int d);
      sync();
      go[d] = 1'b1;
      sync();
      go[d] = 1'b0;
   endtask

   task automatic send_elem(input int d, input logic [63:0] r, input logic [63:0] i);
      sync();
      in_real[d] = r;
      in_imag[d] = i;
      in_stb[d]  = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (in_ack[d]) break;
      end
      if (!in_ack[d]) checkOutput("load accept", in_ack[d], 1);
      sync();
      in_stb[d] = 1'b0;
   endtask

   task automatic wait_res(input int d, input string name);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (res_stb[d]) break;
      end
      checkOutput({name, " res_stb"}, res_stb[d], 1);
   endtask

   task automatic wait_valid(input int d);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (valid[d]) break;
      end
      checkOutput("valid rises", valid[d], 1);
   endtask

   task automatic applyStimulus(input int d, input vec_t v);
      pulse_go(d);
      send_elem(d, ONE, ZERO);
      send_elem(d, ZERO, ONE);
      send_elem(d, v.ar0, v.ai0);
      send_elem(d, v.ar1, v.ai1);
   endtask

   vec_t vecs[6];
   int   base, base2;

   initial begin
      #300000;
      $display("[TB] FAIL global timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      vecs[0] = '{"row 2,3",     TWO,  ZERO, THREE, ZERO, TWO,  THREE};
      vecs[1] = '{"row 0,1",     ZERO, ZERO, ONE,   ZERO, ZERO, ONE};
      vecs[2] = '{"row 1,1",     ONE,  ZERO, ONE,   ZERO, ONE,  ONE};
      vecs[3] = '{"row -1,0.5",  MONE, ZERO, HALF,  ZERO, MONE, HALF};
      vecs[4] = '{"row j,0",     ZERO, ONE,  ZERO,  ZERO, ZERO, ONE};
      vecs[5] = '{"row 0,2j",    ZERO, ZERO, ZERO,  TWO,  MTWO, ZERO};

      for (int d = 0; d < 2; d++) begin
         go[d] = 1'b0; in_stb[d] = 1'b0; res_ack[d] = 1'b0;
         in_real[d] = '0; in_imag[d] = '0;
         resp_lat[d] = 2; resp_never[d] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst busy",    busy[0],     0);
      checkOutput("rst in_ack",  in_ack[0],   0);
      checkOutput("rst valid",   valid[0],    0);
      checkOutput("rst res_stb", res_stb[1],  0);
      checkOutput("rst err",     err[0],      0);
      checkOutput("rst b_real",  b_real[0],   0);
      checkOutput("rst res",     res_real[1], 0);
      sync();
      rst = 1'b0;

      // rows=1 table: one job per entry, result held until acknowledged
      for (int v = 0; v < 6; v++) begin
         base = acc_cnt[0];
         applyStimulus(0, vecs[v]);
         wait_res(0, vecs[v].name);
         checkOutput({vecs[v].name, " res_real"}, res_real[0], vecs[v].er);
         checkOutput({vecs[v].name, " res_imag"}, res_imag[0], vecs[v].ei);
         if (v == 0) begin
            checkOutput("x b_real", b_real[0], X_BR);
            checkOutput("x b_imag", b_imag[0], X_BI);
            checkOutput("row a_real", a_real[0], {THREE, TWO});
            checkOutput("row a_imag", a_imag[0], 0);
            repeat (2) @(negedge clk);
            checkOutput("hold res_stb", res_stb[0], 1);
            checkOutput("hold res_real", res_real[0], TWO);
         end
         sync();
         res_ack[0] = 1'b1;
         sync();
         res_ack[0] = 1'b0;
         @(negedge clk);
         checkOutput({vecs[v].name, " res_stb drop"}, res_stb[0], 0);
         checkOutput({vecs[v].name, " busy end"}, busy[0], 0);
         repeat (8) @(negedge clk);
         checkOutput({vecs[v].name, " one result"}, acc_cnt[0] - base, 1);
      end

      // rows=2 with res_ack tied high: x loaded once, two results
      base  = emit_cyc[1];
      base2 = load_cnt[1];
      res_ack[1] = 1'b1;
      pulse_go(1);
      send_elem(1, ONE, ZERO);
      send_elem(1, ZERO, ONE);
      send_elem(1, TWO, ZERO);
      send_elem(1, THREE, ZERO);
      wait_res(1, "rows2 first");
      checkOutput("rows2 first real", res_real[1], TWO);
      checkOutput("rows2 first imag", res_imag[1], THREE);
      checkOutput("rows2 busy mid", busy[1], 1);
      send_elem(1, ZERO, ZERO);
      send_elem(1, ONE, ZERO);
      wait_res(1, "rows2 second");
      checkOutput("rows2 second real", res_real[1], ZERO);
      checkOutput("rows2 second imag", res_imag[1], ONE);
      repeat (10) @(negedge clk);
      checkOutput("rows2 busy end", busy[1], 0);
      checkOutput("rows2 pulses", emit_cyc[1] - base, 2);
      checkOutput("rows2 loads", load_cnt[1] - base2, 6);
      checkOutput("rows2 x kept", b_imag[1], X_BI);
      res_ack[1] = 1'b0;

      // go while busy and in_stb during ISSUE/WAIT_DONE are ignored
      resp_lat[0] = 6;
      base2 = load_cnt[0];
      pulse_go(0);
      send_elem(0, ONE, ZERO);
      pulse_go(0);
      send_elem(0, ZERO, ONE);
      send_elem(0, TWO, ZERO);
      send_elem(0, THREE, ZERO);
      in_real[0] = 64'hDEADBEEFDEADBEEF;
      in_stb[0]  = 1'b1;
      @(negedge clk);
      checkOutput("ignore in_ack issue", in_ack[0], 0);
      sync();
      in_stb[0] = 1'b0;
      go[0]     = 1'b1;
      sync();
      go[0]     = 1'b0;
      in_stb[0] = 1'b1;
      @(negedge clk);
      checkOutput("ignore in_ack wait", in_ack[0], 0);
      checkOutput("ignore go valid", valid[0], 1);
      sync();
      in_stb[0] = 1'b0;
      wait_res(0, "ignore");
      checkOutput("ignore res_real", res_real[0], TWO);
      checkOutput("ignore res_imag", res_imag[0], THREE);
      checkOutput("ignore loads", load_cnt[0] - base2, 4);
      sync();
      res_ack[0] = 1'b1;
      sync();
      res_ack[0] = 1'b0;

      // reset during WAIT_DONE, then a clean job
      resp_lat[0] = 20;
      applyStimulus(0, vecs[2]);
      wait_valid(0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midrst valid",   valid[0],   0);
      checkOutput("midrst start",   start[0],   0);
      checkOutput("midrst busy",    busy[0],    0);
      checkOutput("midrst res_stb", res_stb[0], 0);
      checkOutput("midrst a_real",  a_real[0],  0);
      sync();
      rst = 1'b0;
      resp_lat[0] = 2;
      applyStimulus(0, vecs[0]);
      wait_res(0, "postrst");
      checkOutput("postrst res_real", res_real[0], TWO);
      checkOutput("postrst res_imag", res_imag[0], THREE);
      sync();
      res_ack[0] = 1'b1;
      sync();
      res_ack[0] = 1'b0;
      repeat (4) @(negedge clk);

      // done never arrives
      resp_never[0] = 1'b1;
      base = emit_cyc[0];
      applyStimulus(0, vecs[0]);
      wait_valid(0);
      repeat (16) @(negedge clk);
      checkOutput("wd cycle16 busy", busy[0], 1);
      checkOutput("wd cycle16 valid", valid[0], 1);
      @(negedge clk);
`ifdef VEC_ACC_DRIVER_TIMEOUT_EN
      checkOutput("wd err", err[0], 1);
      checkOutput("wd busy", busy[0], 0);
      checkOutput("wd valid", valid[0], 0);
      checkOutput("wd ora pulse", out_read_ack[0], 1);
      @(negedge clk);
      checkOutput("wd ora end", out_read_ack[0], 0);
      checkOutput("wd no result", emit_cyc[0] - base, 0);
      pulse_go(0);
      @(negedge clk);
      checkOutput("wd err clear", err[0], 0);
`else
      checkOutput("nowd err", err[0], 0);
      checkOutput("nowd busy", busy[0], 1);
      repeat (20) @(negedge clk);
      checkOutput("nowd valid held", valid[0], 1);
      checkOutput("nowd no result", emit_cyc[0] - base, 0);
`endif
      rst = 1'b1;
      sync();
      rst = 1'b0;
      resp_never[0] = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("final busy", busy[0], 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
